label_addr_checker: RTL and testbench
=====================================

Name: label_addr_checker

Overview:
- Registered, parametrised successor to the combinational address decoder.
- Holds a writable label table of LABEL_NUM entries (base, count, type, defined bit).
- Accepts pointer-access requests (label id, requested type, offset) through a valid/ready handshake and returns the physical address plus an invalid flag and an error code, 2 cycles later.
- Sits between the instruction decode stage and the memory controller.

Parameters:
- ADDR_W, 16, width of base, count, offset and address.
- TYPE_W, 8, width of label type codes.
- LABEL_NUM, 64, number of label table entries.
- LBID_W, 8, width of label id fields; LABEL_NUM <= 2^LBID_W.
- ERRCNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tbl_we  in  1  label table write strobe.
- tbl_lbid  in  LBID_W  entry to write.
- tbl_base  in  ADDR_W  base address to store.
- tbl_count  in  ADDR_W  element count to store.
- tbl_type  in  TYPE_W  label type to store.
- tbl_clear  in  1  clears every defined bit.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_lbid  in  LBID_W  label id.
- req_type  in  TYPE_W  requested type.
- req_ofs  in  ADDR_W  element offset.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_addr  out  ADDR_W  base + ofs, modulo 2^ADDR_W.
- resp_invalid  out  1  1 when resp_err != 0.
- resp_err  out  3  error code (see Behaviour).
- err_count  out  ERRCNT_W  count of invalid responses delivered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All defined bits = 0.
  - Both pipeline stages empty.
  - resp_valid = 0; resp_addr, resp_err and resp_invalid = 0.
  - err_count = 0.
  - req_ready = 1 after reset releases.
  - Reset mid-operation drops all in-flight requests with no response.
- Table writes:
  - On tbl_we with tbl_lbid < LABEL_NUM: the entry is updated at the edge and its defined bit is set.
  - tbl_lbid >= LABEL_NUM: the write is ignored.
  - tbl_clear has priority over a simultaneous tbl_we; the entry stays undefined.
- Read/write ordering:
  - A request accepted in the same cycle as a write to the same label sees the pre-write contents.
  - There is no bypass.
- Stage A (accept):
  - Captures the request and the table fields at the accepting edge.
- Stage B (check):
  - Computes the address and error code and registers them at the next edge.
  - resp_valid is asserted 2 edges after acceptance when there is no backpressure.
- Flow control:
  - advB = !B_valid || resp_ready.
  - req_ready = !A_valid || advB.
  - Throughput is 1 request per cycle when resp_ready is held high.
  - While resp_valid && !resp_ready, all resp_* outputs are held stable.
- Error code, checked in priority order (first match wins):
  - 1: lbid >= LABEL_NUM.
  - 2: label not defined.
  - 3: req_type is not a valid label type. Valid types are the 14 LBTYPE_ codes VPTR, SINT/UINT 1/2/4/8/16/32 and CODE; UNDEFINED and any other code are invalid.
  - 4: req_type != stored type.
  - 5: ofs >= count, unsigned.
  - 6: base + ofs carries out of ADDR_W bits.
  - 0: OK.
- Address output:
  - resp_addr is always the truncated sum, even when the response is invalid.
- Error counter:
  - err_count increments by 1 on each response handshake with resp_invalid = 1.
  - It saturates at all-ones.

Decomposition:
- Shared package (def.v): LBTYPE_* codes, the ERR_* codes 0-6, and the isValidLabelType function. This lets the decoder and this block share one definition.
- Natural sub-module: label_table, holding the storage, the defined bits, clear and write logic, and a combinational read port.
- The pipeline and check logic stay in the top module.

Test Plan:
- Reset, then write lbid 3 = {base 16'hff00, count 16'h00ff, LBTYPE_CODE}. Request lbid 3, CODE, ofs 4 → 2 cycles later resp_addr = 16'hff04, resp_err = 0, resp_invalid = 0.
- Request lbid 5 (never written) → resp_err = 2. Request lbid 64 → resp_err = 1. err_count = 2.
- lbid 3, request VPTR → err 4. Request UNDEFINED → err 3. count = 4 with ofs 4 → err 5. ofs 3 → addr 16'hff03, err 0.
- base 16'hfff0, count 16'h0100, ofs 16'h0020 → err 6 with resp_addr = 16'h0010.
- Back-to-back requests with resp_ready low for 3 cycles:
  - req_ready drops after 2 requests are accepted.
  - resp_* holds the first response.
  - On release, responses arrive in order with none lost.
- Simultaneous tbl_we on lbid 3 (new base 16'h1000) and request to lbid 3 → response uses 16'hff00. A request in the next cycle uses 16'h1000. tbl_clear + tbl_we → err 2. rst_n pulsed mid-stream → resp_valid = 0 immediately and err_count = 0.

Source files
------------

// File: rtl/label_addr_checker_pkg.sv
// Shared label-type and error-code definitions for the address decoder and
// the registered label_addr_checker.
package label_addr_checker_pkg;

  localparam int unsigned LBTYPE_W = 8;

  typedef enum logic [LBTYPE_W-1:0] {
    LBTYPE_UNDEFINED = 8'd0,
    LBTYPE_VPTR      = 8'd1,
    LBTYPE_SINT1     = 8'd2,
    LBTYPE_UINT1     = 8'd3,
    LBTYPE_SINT2     = 8'd4,
    LBTYPE_UINT2     = 8'd5,
    LBTYPE_SINT4     = 8'd6,
    LBTYPE_UINT4     = 8'd7,
    LBTYPE_SINT8     = 8'd8,
    LBTYPE_UINT8     = 8'd9,
    LBTYPE_SINT16    = 8'd10,
    LBTYPE_UINT16    = 8'd11,
    LBTYPE_SINT32    = 8'd12,
    LBTYPE_UINT32    = 8'd13,
    LBTYPE_CODE      = 8'd14
  } lbtype_e;

  typedef enum logic [2:0] {
    ERR_OK            = 3'd0,
    ERR_LBID          = 3'd1,
    ERR_UNDEF         = 3'd2,
    ERR_TYPE          = 3'd3,
    ERR_TYPE_MISMATCH = 3'd4,
    ERR_RANGE         = 3'd5,
    ERR_OVERFLOW      = 3'd6
  } err_e;

  // Wide argument so callers with any type width up to 32 bits can use it;
  // the valid codes form the contiguous run VPTR..CODE.
  function automatic logic isValidLabelType(input logic [31:0] t);
    return (t >= 32'(LBTYPE_VPTR)) && (t <= 32'(LBTYPE_CODE));
  endfunction

endpackage

// File: rtl/label_addr_checker_label_table.sv
// Label table: per-entry base/count/type storage, defined bits with global
// clear, and a combinational read port.
module label_table
  import label_addr_checker_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TYPE_W    = 8,
  parameter int unsigned LABEL_NUM = 64,
  parameter int unsigned LBID_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [LBID_W-1:0] wr_lbid_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic              clear_i,
  input  logic [LBID_W-1:0] rd_lbid_i,
  output logic [ADDR_W-1:0] rd_base_o,
  output logic [ADDR_W-1:0] rd_count_o,
  output logic [TYPE_W-1:0] rd_type_o,
  output logic              rd_def_o
);

  localparam int unsigned IDX_W = (LABEL_NUM > 1) ? $clog2(LABEL_NUM) : 1;

  logic [ADDR_W-1:0]    base_q  [LABEL_NUM];
  logic [ADDR_W-1:0]    count_q [LABEL_NUM];
  logic [TYPE_W-1:0]    type_q  [LABEL_NUM];
  logic [LABEL_NUM-1:0] def_q;

  logic [IDX_W-1:0] widx, ridx;
  logic             wr_in, rd_in, wr_en;

  assign widx  = wr_lbid_i[IDX_W-1:0];
  assign ridx  = rd_lbid_i[IDX_W-1:0];
  assign wr_in = 32'(wr_lbid_i) < LABEL_NUM;
  assign rd_in = 32'(rd_lbid_i) < LABEL_NUM;
  // A clear in the same cycle wins, so the entry is neither stored nor defined.
  assign wr_en = we_i && wr_in && !clear_i;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      base_q[widx]  <= base_i;
      count_q[widx] <= count_i;
      type_q[widx]  <= type_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       def_q       <= '0;
    else if (clear_i) def_q       <= '0;
    else if (wr_en)   def_q[widx] <= 1'b1;
  end

  assign rd_base_o  = rd_in ? base_q[ridx]  : '0;
  assign rd_count_o = rd_in ? count_q[ridx] : '0;
  assign rd_type_o  = rd_in ? type_q[ridx]  : '0;
  assign rd_def_o   = rd_in && def_q[ridx];

endmodule

// File: rtl/label_addr_checker.sv
// Registered label/pointer checker: accept stage samples request and table
// entry, check stage registers address and error code; valid/ready on both ends.
module label_addr_checker
  import label_addr_checker_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TYPE_W    = 8,
  parameter int unsigned LABEL_NUM = 64,
  parameter int unsigned LBID_W    = 8,
  parameter int unsigned ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tbl_we,
  input  logic [LBID_W-1:0]   tbl_lbid,
  input  logic [ADDR_W-1:0]   tbl_base,
  input  logic [ADDR_W-1:0]   tbl_count,
  input  logic [TYPE_W-1:0]   tbl_type,
  input  logic                tbl_clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LBID_W-1:0]   req_lbid,
  input  logic [TYPE_W-1:0]   req_type,
  input  logic [ADDR_W-1:0]   req_ofs,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic                resp_invalid,
  output logic [2:0]          resp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [ADDR_W-1:0] rd_base, rd_count;
  logic [TYPE_W-1:0] rd_type;
  logic              rd_def;

  label_table #(
    .ADDR_W   (ADDR_W),
    .TYPE_W   (TYPE_W),
    .LABEL_NUM(LABEL_NUM),
    .LBID_W   (LBID_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (tbl_we),
    .wr_lbid_i (tbl_lbid),
    .base_i    (tbl_base),
    .count_i   (tbl_count),
    .type_i    (tbl_type),
    .clear_i   (tbl_clear),
    .rd_lbid_i (req_lbid),
    .rd_base_o (rd_base),
    .rd_count_o(rd_count),
    .rd_type_o (rd_type),
    .rd_def_o  (rd_def)
  );

  logic              a_valid_q, a_valid_d, a_def_q;
  logic [LBID_W-1:0] a_lbid_q;
  logic [TYPE_W-1:0] a_type_q, a_stype_q;
  logic [ADDR_W-1:0] a_ofs_q, a_base_q, a_count_q;

  logic                b_valid_q, b_valid_d;
  logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
  err_e                b_err_q, b_err_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  logic        adv_b, accept;
  logic [ADDR_W:0] sum;
  err_e        err;

  assign adv_b     = !b_valid_q || resp_ready;
  assign req_ready = !a_valid_q || adv_b;
  assign accept    = req_valid && req_ready;
  assign a_valid_d = req_ready ? req_valid : a_valid_q;

  // Table fields are sampled with the request, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lbid_q  <= req_lbid;
      a_type_q  <= req_type;
      a_ofs_q   <= req_ofs;
      a_base_q  <= rd_base;
      a_count_q <= rd_count;
      a_stype_q <= rd_type;
      a_def_q   <= rd_def;
    end
  end

  assign sum = {1'b0, a_base_q} + {1'b0, a_ofs_q};

  always_comb begin
    err = ERR_OK;
    if (32'(a_lbid_q) >= LABEL_NUM)               err = ERR_LBID;
    else if (!a_def_q)                            err = ERR_UNDEF;
    else if (!isValidLabelType(32'(a_type_q)))    err = ERR_TYPE;
    else if (a_type_q != a_stype_q)               err = ERR_TYPE_MISMATCH;
    else if (a_ofs_q >= a_count_q)                err = ERR_RANGE;
    else if (sum[ADDR_W])                         err = ERR_OVERFLOW;
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_addr_d  = b_addr_q;
    b_err_d   = b_err_q;
    if (adv_b) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_addr_d = sum[ADDR_W-1:0];
        b_err_d  = err;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (b_valid_q && resp_ready && (b_err_q != ERR_OK) && (cnt_q != '1))
      cnt_d = cnt_q + ERRCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_addr_q  <= '0;
      b_err_q   <= ERR_OK;
      cnt_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      b_addr_q  <= b_addr_d;
      b_err_q   <= b_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign resp_valid   = b_valid_q;
  assign resp_addr    = b_addr_q;
  assign resp_err     = b_err_q;
  assign resp_invalid = (b_err_q != ERR_OK);
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_label_addr_checker.sv
// Self-checking bench for label_addr_checker: directed vector table, hand
// sequences for backpressure / ordering / reset, and a randomized phase.
module tb_label_addr_checker;
  import label_addr_checker_pkg::*;

  localparam int LN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0, tbl_clear = 1'b0;
  logic [7:0]  tbl_lbid = '0, tbl_type = '0;
  logic [15:0] tbl_base = '0, tbl_count = '0;
  logic        req_valid = 1'b0, resp_ready = 1'b1;
  logic [7:0]  req_lbid = '0, req_type = '0;
  logic [15:0] req_ofs = '0;
  logic        req_ready, resp_valid, resp_invalid;
  logic [15:0] resp_addr, err_count;
  logic [2:0]  resp_err;

  label_addr_checker #(
    .ADDR_W(16), .TYPE_W(8), .LABEL_NUM(64), .LBID_W(8), .ERRCNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_lbid(tbl_lbid), .tbl_base(tbl_base),
    .tbl_count(tbl_count), .tbl_type(tbl_type), .tbl_clear(tbl_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_lbid(req_lbid),
    .req_type(req_type), .req_ofs(req_ofs),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
    .resp_invalid(resp_invalid), .resp_err(resp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: table contents plus a queue of in-flight responses,
  // each tagged with the number of edges since it was accepted.
  typedef struct {
    logic [15:0] addr;
    logic [2:0]  err;
    int unsigned age;
  } item_t;

  item_t       q[$];
  logic [15:0] m_base[LN];
  logic [15:0] m_cnt[LN];
  logic [7:0]  m_type[LN];
  bit          m_def[LN];
  logic [15:0] m_errcnt = '0;
  int unsigned n_cmp = 0, n_bad = 0, resp_seen = 0;
  bit          last_acc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic item_t predict(input logic [7:0] lb, input logic [7:0] t,
                                    input logic [15:0] ofs);
    item_t it;
    int    li, s;
    it.age  = 0;
    it.addr = ofs;
    li = int'(lb);
    if (li >= LN) begin
      it.err = 3'd1;
      return it;
    end
    s = int'(m_base[lb[5:0]]) + int'(ofs);
    it.addr = 16'(s % 65536);
    if (!m_def[lb[5:0]])                it.err = 3'd2;
    else if (t < 8'd1 || t > 8'd14)     it.err = 3'd3;
    else if (t != m_type[lb[5:0]])      it.err = 3'd4;
    else if (ofs >= m_cnt[lb[5:0]])     it.err = 3'd5;
    else if (s > 65535)                 it.err = 3'd6;
    else                                it.err = 3'd0;
    return it;
  endfunction

  task automatic model_reset();
    q.delete();
    m_errcnt = '0;
    for (int i = 0; i < LN; i++) m_def[i] = 1'b0;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && (q[0].age >= 1);
    chk("req_ready", 32'(req_ready), 32'((q.size() < 2) || resp_ready));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) begin
      // Address of unknown / undefined labels is not predictable from the model.
      if (q[0].err > 3'd2) chk("resp_addr", 32'(resp_addr), 32'(q[0].addr));
      chk("resp_err", 32'(resp_err), 32'(q[0].err));
      chk("resp_invalid", 32'(resp_invalid), 32'(q[0].err != 3'd0));
    end
    chk("err_count", 32'(err_count), 32'(m_errcnt));
  endtask

  task automatic model_update();
    bit    rdy, hs, acc;
    item_t it;
    rdy = (q.size() < 2) || resp_ready;
    hs  = (q.size() > 0) && (q[0].age >= 1) && resp_ready;
    acc = req_valid && rdy;
    it  = predict(req_lbid, req_type, req_ofs);
    if (hs) begin
      if (q[0].err != 3'd0 && m_errcnt != 16'hffff) m_errcnt = m_errcnt + 16'd1;
      void'(q.pop_front());
      resp_seen++;
    end
    foreach (q[i]) q[i].age = q[i].age + 1;
    if (acc) q.push_back(it);
    if (tbl_clear) begin
      for (int i = 0; i < LN; i++) m_def[i] = 1'b0;
    end else if (tbl_we && int'(tbl_lbid) < LN) begin
      m_base[tbl_lbid[5:0]] = tbl_base;
      m_cnt[tbl_lbid[5:0]]  = tbl_count;
      m_type[tbl_lbid[5:0]] = tbl_type;
      m_def[tbl_lbid[5:0]]  = 1'b1;
    end
    last_acc = acc;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    tbl_we    = 1'b0;
    tbl_clear = 1'b0;
    req_valid = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  wlb;
    logic [15:0] wbase, wcnt;
    logic [7:0]  wtype;
    logic [7:0]  rlb, rtype;
    logic [15:0] rofs;
    logic [2:0]  err;
    bit          chk_addr;
    logic [15:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s0;
    bit          got;

    vt[0]  = '{1'b1, 8'd3,   16'hff00, 16'h00ff, LBTYPE_CODE,   8'd3,   LBTYPE_CODE,   16'd4,    3'd0, 1'b1, 16'hff04, 16'd0};
    vt[1]  = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd5,   LBTYPE_CODE,   16'd0,    3'd2, 1'b0, 16'h0000, 16'd1};
    vt[2]  = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd64,  LBTYPE_CODE,   16'd0,    3'd1, 1'b0, 16'h0000, 16'd2};
    vt[3]  = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd3,   LBTYPE_VPTR,   16'd4,    3'd4, 1'b1, 16'hff04, 16'd3};
    vt[4]  = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd3,   LBTYPE_UNDEFINED, 16'd4, 3'd3, 1'b1, 16'hff04, 16'd4};
    vt[5]  = '{1'b1, 8'd3,   16'hff00, 16'h0004, LBTYPE_CODE,   8'd3,   LBTYPE_CODE,   16'd4,    3'd5, 1'b1, 16'hff04, 16'd5};
    vt[6]  = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd3,   LBTYPE_CODE,   16'd3,    3'd0, 1'b1, 16'hff03, 16'd5};
    vt[7]  = '{1'b1, 8'd7,   16'hfff0, 16'h0100, LBTYPE_UINT16, 8'd7,   LBTYPE_UINT16, 16'h0020, 3'd6, 1'b1, 16'h0010, 16'd6};
    vt[8]  = '{1'b1, 8'd200, 16'h1234, 16'h0100, LBTYPE_CODE,   8'd200, LBTYPE_CODE,   16'd0,    3'd1, 1'b0, 16'h0000, 16'd7};
    vt[9]  = '{1'b1, 8'd63,  16'h0000, 16'hffff, LBTYPE_SINT32, 8'd63,  LBTYPE_SINT32, 16'hfffe, 3'd0, 1'b1, 16'hfffe, 16'd7};
    vt[10] = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd63,  8'd15,         16'd0,    3'd3, 1'b1, 16'h0000, 16'd8};
    vt[11] = '{1'b0, 8'd0,   16'h0000, 16'h0000, 8'd0,          8'd8,   LBTYPE_CODE,   16'd0,    3'd2, 1'b0, 16'h0000, 16'd9};

    // Reset state
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_addr", 32'(resp_addr), 32'(0));
    chk("rst_resp_err", 32'(resp_err), 32'(0));
    chk("rst_resp_invalid", 32'(resp_invalid), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    model_reset();
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(1));

    // Directed vectors
    foreach (vt[k]) begin
      idle();
      if (vt[k].we) begin
        tbl_we = 1'b1; tbl_lbid = vt[k].wlb; tbl_base = vt[k].wbase;
        tbl_count = vt[k].wcnt; tbl_type = vt[k].wtype;
        step();
        idle();
      end
      req_valid = 1'b1; req_lbid = vt[k].rlb; req_type = vt[k].rtype; req_ofs = vt[k].rofs;
      step();
      idle();
      step();
      chk($sformatf("vec%0d_valid", k), 32'(resp_valid), 32'(1));
      chk($sformatf("vec%0d_err", k), 32'(resp_err), 32'(vt[k].err));
      chk($sformatf("vec%0d_invalid", k), 32'(resp_invalid), 32'(vt[k].err != 3'd0));
      if (vt[k].chk_addr) chk($sformatf("vec%0d_addr", k), 32'(resp_addr), 32'(vt[k].addr));
      step();
      chk($sformatf("vec%0d_errcnt", k), 32'(err_count), 32'(vt[k].cnt));
    end

    // Backpressure: entry 3 is {ff00, 0004, CODE}
    idle();
    s0 = resp_seen;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_lbid = 8'd3; req_type = LBTYPE_CODE; req_ofs = 16'd0;
    step();
    req_ofs = 16'd1;
    step();
    chk("bp_ready_low", 32'(req_ready), 32'(0));
    chk("bp_head_addr", 32'(resp_addr), 32'(16'hff00));
    req_ofs = 16'd2;
    step();
    chk("bp_hold_valid", 32'(resp_valid), 32'(1));
    chk("bp_hold_addr1", 32'(resp_addr), 32'(16'hff00));
    step();
    chk("bp_hold_addr2", 32'(resp_addr), 32'(16'hff00));
    resp_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_third_accepted", 32'(got), 32'(1));
    idle();
    for (int n = 0; n < 4; n++) step();
    chk("bp_delivered", 32'(resp_seen - s0), 32'(3));

    // Same-edge write and request: request sees the old base
    idle();
    tbl_we = 1'b1; tbl_lbid = 8'd3; tbl_base = 16'h1000; tbl_count = 16'h00ff; tbl_type = LBTYPE_CODE;
    req_valid = 1'b1; req_lbid = 8'd3; req_type = LBTYPE_CODE; req_ofs = 16'd1;
    step();
    tbl_we = 1'b0;
    step();
    idle();
    chk("rw_old_addr", 32'(resp_addr), 32'(16'hff01));
    step();
    chk("rw_new_addr", 32'(resp_addr), 32'(16'h1001));
    step();

    // Clear beats a simultaneous write
    tbl_clear = 1'b1; tbl_we = 1'b1; tbl_lbid = 8'd3; tbl_base = 16'h2000;
    step();
    idle();
    req_valid = 1'b1; req_lbid = 8'd3; req_type = LBTYPE_CODE; req_ofs = 16'd0;
    step();
    idle();
    step();
    chk("clr_err", 32'(resp_err), 32'(2));
    step();

    // Reset mid-stream
    tbl_we = 1'b1; tbl_lbid = 8'd3; tbl_base = 16'h0100; tbl_count = 16'h0010; tbl_type = LBTYPE_CODE;
    step();
    tbl_we = 1'b0;
    req_valid = 1'b1; req_lbid = 8'd3; req_type = LBTYPE_VPTR; req_ofs = 16'd0;
    for (int n = 0; n < 3; n++) step();
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("mid_rst_err_count", 32'(err_count), 32'(0));
    chk("mid_rst_resp_err", 32'(resp_err), 32'(0));
    model_reset();
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready", 32'(req_ready), 32'(1));

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] lb;
      tbl_we    = ($urandom_range(0, 3) == 0);
      tbl_clear = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 9))
        0:       tbl_lbid = 8'd63;
        1:       tbl_lbid = 8'd64;
        default: tbl_lbid = 8'($urandom_range(0, 5));
      endcase
      tbl_base  = $urandom_range(0, 1) ? 16'($urandom_range(0, 255))
                                       : 16'(32'hff00 + $urandom_range(0, 255));
      tbl_count = 16'($urandom_range(1, 128));
      tbl_type  = 8'($urandom_range(1, 14));
      case ($urandom_range(0, 9))
        0:       lb = 8'd63;
        1:       lb = 8'd64;
        2:       lb = 8'd255;
        default: lb = 8'($urandom_range(0, 5));
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      req_lbid  = lb;
      if (int'(lb) < LN && $urandom_range(0, 1) == 1 && m_def[lb[5:0]])
        req_type = m_type[lb[5:0]];
      else
        req_type = 8'($urandom_range(0, 16));
      req_ofs    = 16'($urandom_range(0, 140));
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    resp_ready = 1'b1;
    for (int n = 0; n < 4; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
